// File: rtl/card_shoe_if.sv
// Handshake bundle between the card shoe and the baccarat hand logic.
// The requester drives deal_req/shuffle; the shoe returns the dealt rank
// together with its occupancy status.
interface card_shoe_if #(
    parameter int DECKS = 1
);
    localparam int LW = $clog2(52 * DECKS + 1);

    logic          deal_req;
    logic          shuffle;
    logic [3:0]    card_out;
    logic          card_valid;
    logic          busy;
    logic [LW-1:0] cards_left;
    logic          shoe_empty;

    // Requester side (hand logic / testbench).
    modport master (
        output deal_req,
        output shuffle,
        input  card_out,
        input  card_valid,
        input  busy,
        input  cards_left,
        input  shoe_empty
    );

    // Shoe side.
    modport slave (
        input  deal_req,
        input  shuffle,
        output card_out,
        output card_valid,
        output busy,
        output cards_left,
        output shoe_empty
    );
endinterface

// File: rtl/card_shoe.sv
// Card shoe: deals ranks 1..13 without replacement from 52*DECKS cards.
// A free-running Galois LFSR proposes a starting rank; the shoe then walks
// upward (13 wraps to 1) until it finds a rank that still has cards.
// A shuffle pulse refills the shoe and aborts any deal in flight.
module card_shoe #(
    parameter int          DECKS = 1,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input logic        slow_clock,
    input logic        resetb,
    card_shoe_if.slave bus
);
    localparam int CW = $clog2(4 * DECKS + 1);
    localparam int LW = $clog2(52 * DECKS + 1);

    localparam logic [CW-1:0] RANK_FULL = CW'(4 * DECKS);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] SHOE_FULL = LW'(52 * DECKS);
    localparam logic [LW-1:0] LEFT_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LEFT_ONE  = {{(LW-1){1'b0}}, 1'b1};
    // Right-shifting Galois mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0]   LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PICK  = 2'd1,
        ST_PROBE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] count_q [13];
    logic [CW-1:0] count_d [13];
    logic [LW-1:0] left_q, left_d;
    logic [3:0]    card_q, card_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;

    logic          hit_s;
    logic          take_s;

    // One step of the Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] shifted;
        shifted = v >> 1;
        if (v[0]) begin
            lfsr_step = shifted ^ LFSR_TAPS;
        end else begin
            lfsr_step = shifted;
        end
    endfunction

    // Fold a random nibble 0..15 onto a starting rank 1..13.
    function automatic logic [3:0] fold_rank(input logic [3:0] nib);
        logic [3:0] r;
        if (nib >= 4'd13) begin
            r = nib - 4'd13;
        end else begin
            r = nib;
        end
        fold_rank = r + 4'd1;
    endfunction

    // Next rank to probe; King wraps back to Ace so every rank is reachable.
    function automatic logic [3:0] next_rank(input logic [3:0] c);
        if (c == 4'd13) begin
            next_rank = 4'd1;
        end else begin
            next_rank = c + 4'd1;
        end
    endfunction

    // Probe hit: the candidate rank still has at least one card.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < 13; i++) begin
            hit_s = hit_s | ((cand_q == 4'(i + 1)) && (count_q[i] != CNT_ZERO));
        end
    end

    // A card leaves the shoe only on a PROBE hit that is not being aborted.
    assign take_s = (state_q == ST_PROBE) && hit_s && !bus.shuffle;

    // Deal sequencer: next state, candidate rank and dealt-card register.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        card_d  = card_q;
        valid_d = 1'b0;
        lfsr_d  = lfsr_step(lfsr_q);
        case (state_q)
            ST_IDLE: begin
                if (bus.shuffle) begin
                    state_d = ST_IDLE;
                end else if (bus.deal_req && (left_q != LEFT_ZERO)) begin
                    state_d = ST_PICK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PICK: begin
                if (bus.shuffle) begin
                    state_d = ST_IDLE;
                end else begin
                    cand_d  = fold_rank(lfsr_q[3:0]);
                    state_d = ST_PROBE;
                end
            end
            ST_PROBE: begin
                if (bus.shuffle) begin
                    state_d = ST_IDLE;
                end else if (hit_s) begin
                    card_d  = cand_q;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cand_d  = next_rank(cand_q);
                    state_d = ST_PROBE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_PICK) || (state_d == ST_PROBE);
    end

    // Shoe occupancy: refill on shuffle, decrement the taken rank on a hit.
    always_comb begin
        for (int i = 0; i < 13; i++) begin
            if (bus.shuffle) begin
                count_d[i] = RANK_FULL;
            end else if (take_s && (cand_q == 4'(i + 1))) begin
                count_d[i] = count_q[i] - CNT_ONE;
            end else begin
                count_d[i] = count_q[i];
            end
        end
        if (bus.shuffle) begin
            left_d = SHOE_FULL;
        end else if (take_s && (left_q != LEFT_ZERO)) begin
            left_d = left_q - LEFT_ONE;
        end else begin
            left_d = left_q;
        end
    end

    // State, LFSR, counters and output registers.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            cand_q  <= 4'd1;
            left_q  <= SHOE_FULL;
            card_q  <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < 13; i++) begin
                count_q[i] <= RANK_FULL;
            end
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cand_q  <= cand_d;
            left_q  <= left_d;
            card_q  <= card_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            for (int i = 0; i < 13; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    assign bus.card_out   = card_q;
    assign bus.card_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.cards_left = left_q;
    assign bus.shoe_empty = (left_q == LEFT_ZERO);
endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: a one-deck and a two-deck shoe driven with identical
// stimulus and checked every cycle against a deal-level model, plus a few
// hand-computed cards and counts.
module tb_card_shoe;
    logic slow_clock = 1'b0;
    logic resetb     = 1'b0;
    logic deal_req   = 1'b0;
    logic shuffle    = 1'b0;

    always #5 slow_clock = ~slow_clock;

    card_shoe_if #(.DECKS(1)) if1 ();
    card_shoe_if #(.DECKS(2)) if2 ();

    assign if1.deal_req = deal_req;
    assign if1.shuffle  = shuffle;
    assign if2.deal_req = deal_req;
    assign if2.shuffle  = shuffle;

    card_shoe #(.DECKS(1), .SEED(16'hACE1)) dut1 (
        .slow_clock(slow_clock),
        .resetb    (resetb),
        .bus       (if1)
    );

    card_shoe #(.DECKS(2), .SEED(16'hACE1)) dut2 (
        .slow_clock(slow_clock),
        .resetb    (resetb),
        .bus       (if2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Deal-level model: per shoe, rank counts, cards left, and the edge
    // countdown until a pending card appears.
    logic [15:0] m_lfsr;
    int m_cnt   [2][13];
    int m_left  [2];
    int m_due   [2];
    int m_card  [2];
    int e_card  [2];
    int e_valid [2];
    int decks   [2];

    int tally   [2][14];
    int n_valid [2];
    int seq     [128];
    int saved   [128];
    int wrap_hits = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic refill(input int d);
        for (int r = 0; r < 13; r++) m_cnt[d][r] = 4 * decks[d];
        m_left[d] = 52 * decks[d];
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        for (int d = 0; d < 2; d++) begin
            refill(d);
            m_due[d]   = 0;
            m_card[d]  = 0;
            e_card[d]  = 0;
            e_valid[d] = 0;
        end
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            n_valid[d] = 0;
            for (int r = 0; r < 14; r++) tally[d][r] = 0;
        end
    endtask

    // Advance the model across one rising edge using the inputs as sampled.
    task automatic model_edge();
        int r;
        int c;
        int k;
        if (!resetb) begin
            model_reset();
        end else begin
            m_lfsr = lfsr_next(m_lfsr);
            for (int d = 0; d < 2; d++) begin
                e_valid[d] = 0;
                if (shuffle) begin
                    refill(d);
                    m_due[d] = 0;
                end else if (m_due[d] > 0) begin
                    m_due[d]--;
                    if (m_due[d] == 0) begin
                        m_cnt[d][m_card[d] - 1]--;
                        m_left[d]--;
                        e_card[d]  = m_card[d];
                        e_valid[d] = 1;
                    end
                end else if (deal_req && m_left[d] > 0) begin
                    // LFSR value here is the one present during the PICK cycle.
                    r = int'(m_lfsr[3:0]) % 13;
                    c = r + 1;
                    k = 0;
                    while (m_cnt[d][c - 1] == 0) begin
                        if (c == 13) wrap_hits++;
                        c = (c % 13) + 1;
                        k++;
                    end
                    m_card[d] = c;
                    m_due[d]  = 2 + k;
                end
            end
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_dut(input int d, input int co, input int cv, input int b,
                             input int left, input int emp);
        int want_busy;
        int want_emp;
        want_busy = (m_due[d] > 0) ? 1 : 0;
        want_emp  = (m_left[d] == 0) ? 1 : 0;
        n_vec++;
        if (co != e_card[d] || cv != e_valid[d] || b != want_busy ||
            left != m_left[d] || emp != want_emp) begin
            n_err++;
            $display("FAIL cycle_shoe%0d @%0t: got card=%0d valid=%0d busy=%0d left=%0d empty=%0d, want card=%0d valid=%0d busy=%0d left=%0d empty=%0d",
                     d + 1, $time, co, cv, b, left, emp,
                     e_card[d], e_valid[d], want_busy, m_left[d], want_emp);
        end
        if (cv == 1 && co >= 1 && co <= 13) begin
            tally[d][co]++;
            if (d == 0 && n_valid[0] < 128) seq[n_valid[0]] = co;
            n_valid[d]++;
        end
    endtask

    // Per-cycle comparison of both shoes against the model.
    task automatic compare_cycle();
        check_dut(0, int'(if1.card_out), int'(if1.card_valid), int'(if1.busy),
                  int'(if1.cards_left), int'(if1.shoe_empty));
        check_dut(1, int'(if2.card_out), int'(if2.card_valid), int'(if2.busy),
                  int'(if2.cards_left), int'(if2.shoe_empty));
    endtask

    task automatic tick();
        @(posedge slow_clock);
        model_edge();
        @(negedge slow_clock);
        compare_cycle();
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        deal_req = 1'b0;
        shuffle = 1'b0;
        model_reset();
        clear_stats();
        tick();
        tick();
        check("rst_card1",  int'(if1.card_out), 0);
        check("rst_valid1", int'(if1.card_valid), 0);
        check("rst_busy1",  int'(if1.busy), 0);
        check("rst_left1",  int'(if1.cards_left), 52);
        check("rst_empty1", int'(if1.shoe_empty), 0);
        check("rst_left2",  int'(if2.cards_left), 104);
        resetb = 1'b1;
    endtask

    initial begin
        int base;
        int busy_seen;
        decks[0] = 1;
        decks[1] = 2;
        model_reset();
        clear_stats();

        // 1: single request straight after reset; PICK sees LFSR 16'hE270 -> Ace.
        do_reset();
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        tick();
        tick();
        check("t1_valid",  int'(if1.card_valid), 1);
        check("t1_card",   int'(if1.card_out), 1);
        check("t1_left1",  int'(if1.cards_left), 51);
        check("t1_left2",  int'(if2.cards_left), 103);
        tick();
        check("t1_busy_after", int'(if1.busy), 0);
        for (int i = 0; i < 4; i++) tick();

        // 2: hold deal_req until the one-deck shoe is exhausted.
        do_reset();
        deal_req = 1'b1;
        for (int i = 0; i < 1500 && n_valid[0] < 52; i++) tick();
        check("t2_deals", n_valid[0], 52);
        check("t2_first_card", seq[0], 1);
        check("t2_second_card", seq[1], 2);
        for (int r = 1; r <= 13; r++) check($sformatf("t2_rank%0d", r), tally[0][r], 4);
        check("t2_left",  int'(if1.cards_left), 0);
        check("t2_empty", int'(if1.shoe_empty), 1);
        for (int i = 0; i < 128; i++) saved[i] = seq[i];
        base = n_valid[0];
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if1.busy === 1'b1) busy_seen++;
        end
        check("t2_empty_no_valid", n_valid[0] - base, 0);
        check("t2_empty_busy", busy_seen, 0);
        deal_req = 1'b0;

        // 3: shuffle refills the empty shoe; next request yields a card.
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        check("t3_left",  int'(if1.cards_left), 52);
        check("t3_empty", int'(if1.shoe_empty), 0);
        check("t3_left2", int'(if2.cards_left), 104);
        base = n_valid[0];
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        for (int i = 0; i < 16 && n_valid[0] == base; i++) tick();
        check("t3_deal", n_valid[0] - base, 1);
        for (int i = 0; i < 16; i++) tick();

        // 4a: shuffle and deal_req together in IDLE; shuffle wins.
        base = n_valid[0];
        shuffle = 1'b1;
        deal_req = 1'b1;
        tick();
        shuffle = 1'b0;
        deal_req = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("t4a_no_valid", n_valid[0] - base, 0);
        check("t4a_left", int'(if1.cards_left), 52);

        // 4b: shuffle sampled in PROBE aborts the deal.
        base = n_valid[0];
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        tick();
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("t4b_no_valid", n_valid[0] - base, 0);
        check("t4b_left", int'(if1.cards_left), 52);
        check("t4b_card_hold", int'(if1.card_out), e_card[0]);

        // 5a: reset asserted between edges while in PROBE.
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        tick();
        resetb = 1'b0;
        model_reset();
        #1;
        check("t5_rst_busy",  int'(if1.busy), 0);
        check("t5_rst_valid", int'(if1.card_valid), 0);
        check("t5_rst_card",  int'(if1.card_out), 0);
        check("t5_rst_left",  int'(if1.cards_left), 52);
        check("t5_rst_busy2", int'(if2.busy), 0);

        // 5b: same seed and timing reproduce the earlier card sequence.
        do_reset();
        deal_req = 1'b1;
        for (int i = 0; i < 400 && n_valid[0] < 10; i++) tick();
        deal_req = 1'b0;
        check("t5_deals", n_valid[0], 10);
        for (int i = 0; i < 10; i++) check($sformatf("t5_repeat%0d", i), seq[i], saved[i]);
        for (int i = 0; i < 16; i++) tick();

        // 6: two-deck shoe dealt to empty; 8 of each rank.
        do_reset();
        deal_req = 1'b1;
        for (int i = 0; i < 3000 && n_valid[1] < 104; i++) tick();
        deal_req = 1'b0;
        check("t6_deals", n_valid[1], 104);
        for (int r = 1; r <= 13; r++) check($sformatf("t6_rank%0d", r), tally[1][r], 8);
        check("t6_left",  int'(if2.cards_left), 0);
        check("t6_empty", int'(if2.shoe_empty), 1);
        check("t6_shoe1_deals", n_valid[0], 52);
        check("king_wrap_seen", (wrap_hits > 0) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
